// File: rtl/id_frame_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : id_frame_parser                                                 |
// | Brief   : Parses letter + 9 digit ID frames, then streams the 10 codes.   |
// |           Define LOWERCASE_EN to also accept 'a'-'z' as the leading char. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module id_frame_parser (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_char,
    output logic       in_ready,
    output logic       out_valid,
    output logic [5:0] out_id,
    output logic       fmt_err
);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_EMIT    = 2'd1,
        S_GAP     = 2'd2
    } state_t;

    localparam logic [3:0] c_LAST_POS  = 4'd9;
    localparam logic [3:0] c_FRAME_LEN = 4'd10;
    localparam logic [1:0] c_GAP_LAST  = 2'd2;

    state_t     r_state;
    state_t     w_state_nx;
    logic [3:0] r_wr_idx;
    logic [3:0] w_wr_idx_nx;
    logic [3:0] r_rd_idx;
    logic [3:0] w_rd_idx_nx;
    logic [1:0] r_gap;
    logic [1:0] w_gap_nx;
    logic       r_in_ready;
    logic       r_out_valid;
    logic       w_out_valid_nx;
    logic [5:0] r_out_id;
    logic [5:0] w_out_id_nx;
    logic       r_fmt_err;
    logic       w_fmt_err_nx;
    logic [5:0] r_buf [0:9];
    logic       w_wr_en;
    logic [5:0] w_wr_code;

    logic [7:0] w_folded;
    logic       w_is_letter;
    logic       w_is_digit;
    logic       w_accept;
    logic       w_char_ok;
    logic [5:0] w_code;

    function automatic logic [5:0] f_letter_code(input logic [7:0] ch);
        case (ch)
            8'h41:   f_letter_code = 6'd10;
            8'h42:   f_letter_code = 6'd11;
            8'h43:   f_letter_code = 6'd12;
            8'h44:   f_letter_code = 6'd13;
            8'h45:   f_letter_code = 6'd14;
            8'h46:   f_letter_code = 6'd15;
            8'h47:   f_letter_code = 6'd16;
            8'h48:   f_letter_code = 6'd17;
            8'h49:   f_letter_code = 6'd34;
            8'h4A:   f_letter_code = 6'd18;
            8'h4B:   f_letter_code = 6'd19;
            8'h4C:   f_letter_code = 6'd20;
            8'h4D:   f_letter_code = 6'd21;
            8'h4E:   f_letter_code = 6'd22;
            8'h4F:   f_letter_code = 6'd35;
            8'h50:   f_letter_code = 6'd23;
            8'h51:   f_letter_code = 6'd24;
            8'h52:   f_letter_code = 6'd25;
            8'h53:   f_letter_code = 6'd26;
            8'h54:   f_letter_code = 6'd27;
            8'h55:   f_letter_code = 6'd28;
            8'h56:   f_letter_code = 6'd29;
            8'h57:   f_letter_code = 6'd32;
            8'h58:   f_letter_code = 6'd30;
            8'h59:   f_letter_code = 6'd31;
            8'h5A:   f_letter_code = 6'd33;
            default: f_letter_code = 6'd0;
        endcase
    endfunction

`ifdef LOWERCASE_EN
    assign w_folded = (in_char >= 8'h61 && in_char <= 8'h7A) ? (in_char - 8'h20) : in_char;
`else
    assign w_folded = in_char;
`endif

    // Digits are checked on the raw character so lowercase never passes there.
    assign w_is_letter = (w_folded >= 8'h41) && (w_folded <= 8'h5A);
    assign w_is_digit  = (in_char >= 8'h30) && (in_char <= 8'h39);
    assign w_accept    = in_valid && r_in_ready;
    assign w_char_ok   = (r_wr_idx == 4'd0) ? w_is_letter : w_is_digit;
    assign w_code      = (r_wr_idx == 4'd0) ? f_letter_code(w_folded) : {2'b00, in_char[3:0]};

    always_comb begin
        w_state_nx     = r_state;
        w_wr_idx_nx    = r_wr_idx;
        w_rd_idx_nx    = r_rd_idx;
        w_gap_nx       = r_gap;
        w_out_valid_nx = 1'b0;
        w_out_id_nx    = 6'd0;
        w_fmt_err_nx   = 1'b0;
        w_wr_en        = 1'b0;
        w_wr_code      = 6'd0;
        case (r_state)
            S_COLLECT: begin
                if (w_accept) begin
                    if (w_char_ok) begin
                        w_wr_en   = 1'b1;
                        w_wr_code = w_code;
                        if (r_wr_idx == c_LAST_POS) begin
                            // Slot 0 was written long ago, so the stream starts on this edge.
                            w_state_nx     = S_EMIT;
                            w_wr_idx_nx    = 4'd0;
                            w_out_valid_nx = 1'b1;
                            w_out_id_nx    = r_buf[0];
                            w_rd_idx_nx    = 4'd1;
                        end else begin
                            w_wr_idx_nx = r_wr_idx + 4'd1;
                        end
                    end else begin
                        w_fmt_err_nx = 1'b1;
                        w_wr_idx_nx  = 4'd0;
                    end
                end
            end
            S_EMIT: begin
                if (r_rd_idx == c_FRAME_LEN) begin
                    w_state_nx  = S_GAP;
                    w_rd_idx_nx = 4'd0;
                    w_gap_nx    = 2'd0;
                end else begin
                    w_out_valid_nx = 1'b1;
                    w_out_id_nx    = r_buf[r_rd_idx];
                    w_rd_idx_nx    = r_rd_idx + 4'd1;
                end
            end
            S_GAP: begin
                if (r_gap == c_GAP_LAST) begin
                    w_state_nx = S_COLLECT;
                end else begin
                    w_gap_nx = r_gap + 2'd1;
                end
            end
            default: begin
                w_state_nx  = S_COLLECT;
                w_wr_idx_nx = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_COLLECT;
            r_wr_idx    <= 4'd0;
            r_rd_idx    <= 4'd0;
            r_gap       <= 2'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_id    <= 6'd0;
            r_fmt_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_wr_idx    <= w_wr_idx_nx;
            r_rd_idx    <= w_rd_idx_nx;
            r_gap       <= w_gap_nx;
            r_in_ready  <= (w_state_nx == S_COLLECT);
            r_out_valid <= w_out_valid_nx;
            r_out_id    <= w_out_id_nx;
            r_fmt_err   <= w_fmt_err_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[r_wr_idx] <= w_wr_code;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_id    = r_out_id;
    assign fmt_err   = r_fmt_err;

endmodule
`default_nettype wire

// File: tb/tb_id_frame_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_id_frame_parser                                              |
// | Brief   : Directed and random frames checked cycle by cycle vs a model.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_id_frame_parser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_char = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [5:0] out_id;
    logic       fmt_err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       v;
        logic [5:0] id;
        logic       e;
        logic       r;
    } exp_t;

    exp_t q[$];
    bit   mdl_ready = 1'b0;
    int   mdl_pos = 0;
    int   mdl_codes[10];
    int   lut[26] = '{10, 11, 12, 13, 14, 15, 16, 17, 34, 18, 19, 20, 21,
                      22, 35, 23, 24, 25, 26, 27, 28, 29, 32, 30, 31, 33};

    id_frame_parser dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_char  (in_char),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_id   (out_id),
        .fmt_err  (fmt_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, want, $time);
        end
    endtask

    // Frame rules: letter then nine digits; a full frame streams 10 codes then 3 quiet cycles.
    task automatic mdl_accept(input logic [7:0] c);
        int ci;
        bit ok;
        int code;
        ci = int'(c);
        ok = 1'b0;
        code = 0;
        if (mdl_pos == 0) begin
            if (ci >= 65 && ci <= 90) begin
                ok = 1'b1;
                code = lut[ci - 65];
            end
`ifdef LOWERCASE_EN
            else if (ci >= 97 && ci <= 122) begin
                ok = 1'b1;
                code = lut[ci - 97];
            end
`endif
        end else if (ci >= 48 && ci <= 57) begin
            ok = 1'b1;
            code = ci - 48;
        end
        if (!ok) begin
            mdl_pos = 0;
            q.push_back('{1'b0, 6'd0, 1'b1, 1'b1});
        end else begin
            mdl_codes[mdl_pos] = code;
            mdl_pos++;
            if (mdl_pos == 10) begin
                for (int i = 0; i < 10; i++) q.push_back('{1'b1, 6'(mdl_codes[i]), 1'b0, 1'b0});
                for (int i = 0; i < 3; i++) q.push_back('{1'b0, 6'd0, 1'b0, 1'b0});
                mdl_pos = 0;
            end
        end
    endtask

    task automatic tick(output bit acc);
        exp_t e;
        acc = (in_valid === 1'b1) && mdl_ready;
        if (acc) mdl_accept(in_char);
        @(posedge clk);
        #1;
        if (q.size() > 0) e = q.pop_front();
        else e = '{1'b0, 6'd0, 1'b0, 1'b1};
        chk("out_valid", {7'd0, out_valid}, {7'd0, e.v});
        chk("out_id", {2'd0, out_id}, {2'd0, e.id});
        chk("fmt_err", {7'd0, fmt_err}, {7'd0, e.e});
        chk("in_ready", {7'd0, in_ready}, {7'd0, e.r});
        mdl_ready = e.r;
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        repeat (n) tick(acc);
    endtask

    task automatic push(input logic [7:0] c, input int gap);
        bit acc;
        int waited;
        idle(gap);
        in_valid = 1'b1;
        in_char = c;
        acc = 1'b0;
        waited = 0;
        while (!acc && waited < 40) begin
            tick(acc);
            waited++;
        end
        chk("accept_timeout", {7'd0, acc}, 8'd1);
        in_valid = 1'b0;
    endtask

    task automatic push_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) push(s[i], gap);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("rst_in_ready", {7'd0, in_ready}, 8'd0);
            chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
            chk("rst_out_id", {2'd0, out_id}, 8'd0);
            chk("rst_fmt_err", {7'd0, fmt_err}, 8'd0);
        end
        q.delete();
        mdl_pos = 0;
        mdl_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        bit acc;
        logic [7:0] c;
        int r;

        do_reset(3);
        idle(2);

        // Back-to-back frame.
        push_str("A123456789", 0);
        idle(16);

        // Two idle cycles between characters; in_ready stays low 13 cycles.
        push_str("Z012345678", 2);
        idle(16);

        // Bad leading character, then a good frame.
        push("1", 0);
        push_str("B987654321", 0);
        idle(16);

        // Letter where a digit belongs; the offending 'X' is not kept.
        push_str("A1X", 0);
        push_str("X123456789", 0);
        idle(16);

        // Reset during the 4th emitted symbol drops the rest of the frame.
        push_str("C123456789", 0);
        tick(acc);
        tick(acc);
        tick(acc);
        do_reset(1);
        idle(20);

        // Lowercase leading letter, and lowercase in a digit slot.
        push_str("a123456789", 0);
        idle(16);
        push_str("D12a", 1);
        push_str("E000000000", 0);
        idle(16);

        // Random characters, biased towards well-formed frames.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 19);
            if (mdl_pos == 0) begin
                if (r == 0) c = 8'(48 + $urandom_range(0, 9));
                else if (r == 1) c = 8'(97 + $urandom_range(0, 25));
                else if (r == 2) c = 8'($urandom_range(0, 255));
                else c = 8'(65 + $urandom_range(0, 25));
            end else begin
                if (r == 0) c = 8'(65 + $urandom_range(0, 25));
                else if (r == 1) c = 8'(97 + $urandom_range(0, 25));
                else if (r == 2) c = 8'($urandom_range(0, 255));
                else c = 8'(48 + $urandom_range(0, 9));
            end
            push(c, $urandom_range(0, 2));
            if (n == 200) begin
                idle($urandom_range(0, 12));
                do_reset(2);
            end
        end
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_frame_parser.md
ID_FRAME_PARSER -- requirements
Module: id_frame_parser

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk input 1 (all state on rising edge); rst_n input 1 (sampled on clk only).
REQ-002 SHALL have in_valid input 1: an ASCII character is offered on in_char.
REQ-003 SHALL have in_char input 8: the ASCII character.
REQ-004 SHALL have in_ready output 1: the parser accepts in_char this cycle.
REQ-005 SHALL have out_valid output 1: out_id carries one frame symbol; drives the downstream ID checker's in_valid.
REQ-006 SHALL have out_id output 6: the symbol code; drives the checker's in_id.
REQ-007 SHALL have fmt_err output 1: a one-cycle pulse when the current frame is discarded as malformed.

Function
REQ-008 SHALL accept a character only when in_valid && in_ready, and SHALL tolerate idle in_valid cycles between characters.
REQ-009 SHALL assemble 10-character frames: position 0 is a letter, positions 1-9 are digits '0'-'9' (0x30-0x39).
REQ-010 SHALL map the letter to a code: A10 B11 C12 D13 E14 F15 G16 H17 I34 J18 K19 L20 M21 N22 O35 P23 Q24 R25 S26 T27 U28 V29 W32 X30 Y31 Z33.
REQ-011 SHALL map each digit to its value 0-9.
REQ-012 SHALL store the codes in a 10-entry x 6-bit buffer with a 4-bit write index.
REQ-013 SHALL implement states COLLECT, EMIT and GAP, with reset entering COLLECT at index 0.
REQ-014 SHALL drive in_ready=1 only in COLLECT and 0 in EMIT and GAP.
REQ-015 SHALL, when the 10th character is accepted at edge k, transition to EMIT, with out_valid high for exactly 10 consecutive cycles following edge k.
REQ-016 SHALL present out_id in buffer order 0..9 while out_valid is high, and drive out_id=0 whenever out_valid=0.
REQ-017 SHALL register out_valid and out_id.
REQ-018 SHALL, after EMIT, hold GAP for 3 cycles with out_valid=0, then return to COLLECT at index 0; this lets the checker report and clear its state.
REQ-019 SHALL treat an invalid character (non-letter at position 0, non-digit at positions 1-9) as follows: pulse fmt_err for 1 cycle after the accept edge, discard the partial frame, reset the index to 0 and remain in COLLECT.
REQ-020 SHALL evaluate the character following an error as position 0.
REQ-021 SHALL never pulse fmt_err while out_valid=1, and SHALL never emit a partial frame.
REQ-022 SHALL keep the index within 0..9, with no wrap-around beyond 9.

Reset
REQ-023 SHALL, with rst_n low at a clock edge, set in_ready=0, out_valid=0, out_id=0, fmt_err=0, index=0 and state=COLLECT.
REQ-024 SHALL assert in_ready from the first cycle after rst_n is released.
REQ-025 SHALL drop a frame that reset interrupts mid-COLLECT or mid-EMIT immediately, without resuming it, and SHALL not emit the remaining symbols.
REQ-026 SHALL not require clearing of buffer contents on reset.

Configuration
REQ-027 SHALL accept lowercase 'a'-'z' (0x61-0x7A) at position 0 when LOWERCASE_EN is defined, mapping each to the same code as its uppercase letter.
REQ-028 SHALL, when LOWERCASE_EN is undefined, treat lowercase at position 0 as invalid and respond as in REQ-019.
REQ-029 SHALL treat lowercase at positions 1-9 as invalid in both builds.

Verification
REQ-030 SHALL cover: "A123456789" (0x41,0x31..0x39) back-to-back -> out_valid 10 cycles, out_id 10,1,2,3,4,5,6,7,8,9; fmt_err never high.
REQ-031 SHALL cover: 'Z','0'..'8' with 2 idle cycles between each character -> out_id 33,0,1,...,8; in_ready low for 13 cycles after the 10th accept.
REQ-032 SHALL cover: '1' at position 0 -> fmt_err pulse; then "B987654321" -> out_id 11,9,8,7,6,5,4,3,2,1.
REQ-033 SHALL cover: 'A','1','X' -> fmt_err on the third character; then 'X' is accepted as the next position 0 (code 30).
REQ-034 SHALL cover: rst_n low at the 4th EMIT cycle -> out_valid=0 and out_id=0 next cycle, in_ready=1 after release, and no further symbols from that frame.
REQ-035 SHALL cover: 'a' at position 0 -> code 10 with LOWERCASE_EN defined; fmt_err pulse without it.
